// File: rtl/wb_stage_mi.sv
// rtl/wb_stage_mi.sv - multi-issue writeback stage with serialising trace FIFO
module wb_stage_mi #(
   parameter int ISSUE_W     = 2,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int TRACE_DEPTH = 8,
   parameter int LANE_W      = 4*DATA_W+ADDR_W+4
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic [5:0]                                      stall,
   input  logic                                            flush,
   input  logic [ISSUE_W*LANE_W-1:0]                       mem_to_wb_bus,
   output logic [ISSUE_W-1:0]                              rf_we,
   output logic [ISSUE_W*ADDR_W-1:0]                       rf_waddr,
   output logic [ISSUE_W*DATA_W-1:0]                       rf_wdata,
   output logic                                            hi_we,
   output logic                                            lo_we,
   output logic [DATA_W-1:0]                               hi_wdata,
   output logic [DATA_W-1:0]                               lo_wdata,
   output logic [2*(DATA_W+1)+ISSUE_W*(1+ADDR_W+DATA_W)-1:0] wb_to_id_bus,
   output logic                                            wb_stall_req,
   output logic                                            trace_ovf,
   output logic [31:0]                                     debug_wb_pc,
   output logic [3:0]                                      debug_wb_rf_wen,
   output logic [4:0]                                      debug_wb_rf_wnum,
   output logic [31:0]                                     debug_wb_rf_wdata
);
   localparam int PTR_W = $clog2(TRACE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 2*DATA_W + ADDR_W + 1;
   localparam int LB_W  = 1 + ADDR_W + DATA_W;

   logic [ISSUE_W*LANE_W-1:0] bundle;
   logic [ISSUE_W-1:0]        l_valid, l_hi_we, l_lo_we, l_rf_we, eff_we, sup, in_valid, acc;
   logic [DATA_W-1:0]         l_hi [ISSUE_W];
   logic [DATA_W-1:0]         l_lo [ISSUE_W];
   logic [DATA_W-1:0]         l_wd [ISSUE_W];
   logic [ADDR_W-1:0]         l_wa [ISSUE_W];
   logic [ENT_W-1:0]          in_ent [ISSUE_W];
   logic [ISSUE_W*LB_W-1:0]   lane_bus;
   logic [ISSUE_W-1:0]        unused_pc;
   logic                      unused_stall;

   logic [ENT_W-1:0] mem [TRACE_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, space, n_acc;
   logic [CNT_W-1:0] off [ISSUE_W];
   logic             pop, drop, load;
   logic [ENT_W-1:0] rd_ent;

   assign load = ~rst & ~flush & ~stall[4];

   always_ff @(posedge clk) begin
      if (rst || flush)
         bundle <= '0;
      else if (stall[4] && !stall[5])
         bundle <= '0;
      else if (!stall[4])
         bundle <= mem_to_wb_bus;
   end

   genvar g;
   generate
      for (g = 0; g < ISSUE_W; g++) begin : g_lane
         localparam int B = g*LANE_W;
         assign l_wd[g]    = bundle[B +: DATA_W];
         assign l_wa[g]    = bundle[B+DATA_W +: ADDR_W];
         assign l_rf_we[g] = bundle[B+DATA_W+ADDR_W];
         assign l_lo[g]    = bundle[B+DATA_W+ADDR_W+1 +: DATA_W];
         assign l_lo_we[g] = bundle[B+2*DATA_W+ADDR_W+1];
         assign l_hi[g]    = bundle[B+2*DATA_W+ADDR_W+2 +: DATA_W];
         assign l_hi_we[g] = bundle[B+3*DATA_W+ADDR_W+2];
         assign unused_pc[g] = ^bundle[B+LANE_W-2 -: DATA_W];
         assign l_valid[g] = bundle[B+LANE_W-1];
         // Trace entry {pc, rf_we, rf_waddr, rf_wdata} from the lane being captured
         assign in_valid[g] = mem_to_wb_bus[B+LANE_W-1];
         assign in_ent[g]   = {mem_to_wb_bus[B+LANE_W-2 -: DATA_W], mem_to_wb_bus[B +: DATA_W+ADDR_W+1]};
         assign rf_waddr[g*ADDR_W +: ADDR_W] = l_wa[g];
         assign rf_wdata[g*DATA_W +: DATA_W] = l_wd[g];
         assign lane_bus[g*LB_W +: LB_W]     = {rf_we[g], l_wa[g], l_wd[g]};
      end
   endgenerate

   assign unused_stall = ^{stall[3:0], unused_pc};
   assign eff_we = l_valid & l_rf_we;

   // Older lane loses to any younger lane writing the same nonzero register
   always_comb begin
      sup = '0;
      for (int i = 0; i < ISSUE_W; i++)
         for (int j = i + 1; j < ISSUE_W; j++)
            if (eff_we[i] && eff_we[j] && l_wa[i] == l_wa[j] && l_wa[i] != '0)
               sup[i] = 1'b1;
   end
   assign rf_we = eff_we & ~sup;

   always_comb begin
      hi_we = 1'b0;
      lo_we = 1'b0;
      hi_wdata = '0;
      lo_wdata = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         if (l_valid[i] && l_hi_we[i]) begin
            hi_we = 1'b1;
            hi_wdata = l_hi[i];
         end
         if (l_valid[i] && l_lo_we[i]) begin
            lo_we = 1'b1;
            lo_wdata = l_lo[i];
         end
      end
   end

   assign wb_to_id_bus = {hi_we, hi_wdata, lo_we, lo_wdata, lane_bus};

   // The slot freed by this edge's pop is usable by this edge's pushes
   always_comb begin
      pop   = (count != '0);
      space = CNT_W'(TRACE_DEPTH) - count + CNT_W'(pop);
      n_acc = '0;
      acc   = '0;
      drop  = 1'b0;
      for (int i = 0; i < ISSUE_W; i++) begin
         off[i] = n_acc;
         if (load && in_valid[i]) begin
            if (n_acc < space) begin
               acc[i] = 1'b1;
               n_acc  = n_acc + CNT_W'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < ISSUE_W; i++)
         if (!rst && acc[i])
            mem[wr_ptr + off[i][PTR_W-1:0]] <= in_ent[i];
   end

   assign rd_ent = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         trace_ovf         <= 1'b0;
         debug_wb_pc       <= '0;
         debug_wb_rf_wen   <= '0;
         debug_wb_rf_wnum  <= '0;
         debug_wb_rf_wdata <= '0;
      end else begin
         wr_ptr <= wr_ptr + n_acc[PTR_W-1:0];
         count  <= count + n_acc - CNT_W'(pop);
         if (drop)
            trace_ovf <= 1'b1;
         if (pop) begin
            rd_ptr            <= rd_ptr + PTR_W'(1);
            debug_wb_pc       <= rd_ent[ENT_W-1 -: DATA_W];
            debug_wb_rf_wen   <= {4{rd_ent[DATA_W+ADDR_W]}};
            debug_wb_rf_wnum  <= rd_ent[DATA_W +: ADDR_W];
            debug_wb_rf_wdata <= rd_ent[DATA_W-1:0];
         end else begin
            debug_wb_rf_wen <= '0;
         end
      end
   end

   assign wb_stall_req = (CNT_W'(TRACE_DEPTH) - count) < CNT_W'(ISSUE_W);
endmodule

// File: doc/wb_stage_mi.md
Name: wb_stage_mi

Overview:
Multi-issue writeback stage. It registers a bundle of ISSUE_W retiring instructions from MEM and drives one register-file write port per lane, a merged HI/LO write, and the matching forwarding bus to ID. Because several instructions retire per cycle, it serialises retirements through a trace FIFO onto the single-port debug interface. It requests a pipeline stall when that FIFO nears full.

Parameters:
ISSUE_W, 2, number of lanes per bundle (1..4)
DATA_W, 32, datapath width
ADDR_W, 5, register-file address width
TRACE_DEPTH, 8, trace FIFO entries (power of two, at least 2*ISSUE_W)
LANE_W, 4*DATA_W+ADDR_W+4, per-lane bus width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stall  in  6  pipeline stall vector; bit4 = WB input hold, bit5 = downstream hold
flush  in  1  squash the bundle being captured this edge
mem_to_wb_bus  in  ISSUE_W*LANE_W  lane i at [i*LANE_W +: LANE_W]; fields MSB→LSB: valid, pc, hi_we, hi, lo_we, lo, rf_we, rf_waddr, rf_wdata
rf_we  out  ISSUE_W  per-lane register-file write enable
rf_waddr  out  ISSUE_W*ADDR_W  per-lane write address
rf_wdata  out  ISSUE_W*DATA_W  per-lane write data
hi_we, lo_we  out  1 each  merged HI/LO write enables
hi_wdata, lo_wdata  out  DATA_W each  merged HI/LO data
wb_to_id_bus  out  2*(DATA_W+1)+ISSUE_W*(1+ADDR_W+DATA_W)  {hi_we, hi_wdata, lo_we, lo_wdata, per-lane {rf_we, rf_waddr, rf_wdata}, lane ISSUE_W-1 first}
wb_stall_req  out  1  trace-FIFO back-pressure request
trace_ovf  out  1  sticky: an entry was dropped
debug_wb_pc  out  32  retired PC
debug_wb_rf_wen  out  4  {4{we}} of retired entry; 0 when idle
debug_wb_rf_wnum  out  5  retired write address
debug_wb_rf_wdata  out  32  retired write data

Behaviour:
- Bundle register:
  - rst or flush → cleared.
  - else stall[4]=1 and stall[5]=0 → cleared (bubble).
  - else stall[4]=0 → load mem_to_wb_bus.
  - else hold.
  - rst has priority over flush; flush has priority over stall.
- Lane with valid=0: all its enables are forced to 0.
- Register-file outputs are combinational from the bundle register. A write is visible to the RF in the same cycle the bundle is held; zero extra latency.
- Intra-bundle WAW: if lanes i<j both write the same nonzero rf_waddr, lane i's rf_we is suppressed. The highest-index (youngest) lane wins. Address 0 is never suppressed.
- HI/LO merge: hi_we is the OR over lanes; hi_wdata comes from the highest-index lane with hi_we=1, else 0. LO is merged the same way.
- wb_to_id_bus carries the post-suppression values.
- Trace FIFO push:
  - On each edge where the bundle register loads, push one entry {pc, rf_we, rf_waddr, rf_wdata} per valid lane, in lane order 0..ISSUE_W-1.
  - Trace entries use the unsuppressed rf_we; the trace shows program-order writes.
  - Flushed and bubble captures push nothing.
- Trace FIFO pop: each edge with count>0, pop one entry into the debug registers. If count=0, debug_wb_rf_wen ← 0 and the other debug outputs hold.
- Debug latency: lane 0 appears at the debug outputs 1 cycle after bundle capture when the FIFO was empty; lane k appears k cycles later.
- Push and pop on the same edge are legal; the count update is count + pushes − pop.
- wb_stall_req = (TRACE_DEPTH − count) < ISSUE_W. It is combinational from the registered count.
- Overflow (stall ignored upstream): lanes that do not fit are dropped in lane order, trace_ovf is set, and the count saturates at TRACE_DEPTH. trace_ovf clears only on rst.
- Pointers wrap modulo TRACE_DEPTH.
- Reset values: bundle register, FIFO pointers, count, trace_ovf and all debug outputs are 0, so every derived output is 0.
- Reset mid-drain discards all FIFO contents.

Test Plan:
1. rst held 2 cycles → all outputs 0; wb_stall_req=0.
2. Bundle {lane0: pc 0xBFC00000, r3←0x11; lane1: pc 0xBFC00004, r4←0x22}, stall=0 → same cycle: rf_we=2'b11. Debug: pc 0xBFC00000 / wnum 3 next cycle; 0xBFC00004 / wnum 4 the cycle after; then wen=0.
3. Both lanes write r5 (0xA, then 0xB) → rf_we=2'b10, r5 receives 0xB. Trace still emits 0xA then 0xB in order.
4. Both lanes set hi_we (hi 0x1, 0x2), lane0 sets lo_we (lo 0x3) → hi_wdata=0x2, lo_wdata=0x3, hi_we=lo_we=1.
5. Back-to-back full bundles with TRACE_DEPTH=8 and stall wired from wb_stall_req → wb_stall_req rises at count 7. A bubble is inserted (stall[4]=1, stall[5]=0) and trace_ovf stays 0. All retirements appear in order.
6. flush asserted with a valid bundle present on mem_to_wb_bus → next cycle rf_we=0 and no trace entries. Entries already queued still drain.
